// File: rtl/rom_seq_ctrl.sv
// Sequences a block ROM into a display register and time-multiplexes the
// latched word onto a 4-digit 7-segment display, all from one clock.
module rom_seq_ctrl #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 16,
  parameter int STEP_BITS = 24,
  parameter int SCAN_BITS = 18,
  parameter int ROM_LAT   = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] disp_data,
  output logic [3:0]        digit,
  output logic [3:0]        an,
  output logic              busy,
  output logic              wrap
);

  localparam logic [1:0] WAIT_LOAD = 2'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_LATCH = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [STEP_BITS-1:0] presc_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   disp_q;
  logic [1:0]          wait_q;
  logic [1:0]          idx_q;
  logic                single_q;
  logic                pstop_q;
  logic                busy_q;
  logic                wrap_q;

  logic                step_tick;
  logic                scan_tick;
  logic                start_acc;
  logic                step_acc;
  logic                tick_acc;
  logic                addr_inc;

  assign step_tick = &presc_q;
  assign scan_tick = &presc_q[SCAN_BITS-1:0];
  assign addr_inc  = step_acc | tick_acc;

  // Prescaler realigns to the start command so the first step lands a full
  // period after the initial fetch.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      presc_q <= '0;
    end else if (start_acc) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + STEP_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    step_acc  = 1'b0;
    tick_acc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!stop) begin
          if (start) begin
            start_acc = 1'b1;
            state_d   = S_WAIT;
          end else if (step) begin
            step_acc = 1'b1;
            state_d  = S_WAIT;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (step_tick) begin
          tick_acc = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 2'd0) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        // A stop arriving in the latch cycle itself is honoured immediately.
        if (single_q || pstop_q || stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      addr_q   <= '0;
      wrap_q   <= 1'b0;
      single_q <= 1'b0;
      wait_q   <= 2'd0;
      pstop_q  <= 1'b0;
      disp_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      wrap_q <= addr_inc && (&addr_q);
      busy_q <= (state_d != S_IDLE);
      if (start_acc) begin
        addr_q <= '0;
      end else if (addr_inc) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (start_acc) begin
        single_q <= 1'b0;
      end else if (step_acc) begin
        single_q <= 1'b1;
      end
      if (state_d == S_WAIT && state_q != S_WAIT) begin
        wait_q <= WAIT_LOAD;
      end else if (state_q == S_WAIT && wait_q != 2'd0) begin
        wait_q <= wait_q - 2'd1;
      end
      if (state_q == S_LATCH) begin
        pstop_q <= 1'b0;
      end else if (state_q == S_WAIT && stop) begin
        pstop_q <= 1'b1;
      end
      if (state_q == S_LATCH) begin
        disp_q <= rom_data;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      idx_q <= 2'd0;
    end else if (scan_tick) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  always_comb begin
    an    = ~(4'b0001 << idx_q);
    digit = disp_q[{idx_q, 2'b00} +: 4];
  end

  assign rom_addr  = addr_q;
  assign disp_data = disp_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/rom_seq_ctrl.md
Name: rom_seq_ctrl

Overview:
Controller that sequences the block ROM and the multiplexed 4-digit 7-segment display from a single system clock. A free-running prescaler replaces derived clocks with one-cycle enable ticks. An FSM steps the ROM address at the step rate, waits out ROM read latency and latches each word into a display register. A scan counter time-multiplexes the four digit nibbles onto the shared segment decoder.

Parameters:
ADDR_W, 4, ROM address width; address wraps at 2^ADDR_W-1.
DATA_W, 16, ROM word width; fixed at 4 nibbles × 4 bits.
STEP_BITS, 24, prescaler width; step_tick period is 2^STEP_BITS cycles.
SCAN_BITS, 18, scan_tick period is 2^SCAN_BITS cycles; must be less than STEP_BITS.
ROM_LAT, 1, ROM read latency in clk cycles (1..3).

Ports:
clk  in  1  system clock, rising edge
clr  in  1  reset, asynchronous, active-low
start  in  1  level-sampled; begin auto-stepping from address 0
stop  in  1  level-sampled; halt auto-stepping
step  in  1  level-sampled; single fetch of the next address when idle
rom_addr  out  ADDR_W  ROM address
rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_addr changes
disp_data  out  DATA_W  latched word being displayed
digit  out  4  nibble for the currently selected digit, to the segment decoder
an  out  4  digit anodes, active-low, one-hot-low
busy  out  1  high whenever state is not IDLE
wrap  out  1  one-cycle pulse when rom_addr rolls from max to 0

Behaviour:
- Reset (clr=0, asynchronous):
  - prescaler=0, state=IDLE, rom_addr=0, disp_data=0.
  - Scan index=0, so an=4'b1110 and digit=0.
  - busy=0, wrap=0, pending_stop=0.
- Prescaler:
  - q increments every cycle and wraps.
  - step_tick=1 for the single cycle in which q[STEP_BITS-1:0] is all ones.
  - scan_tick=1 when q[SCAN_BITS-1:0] is all ones.
  - q clears to 0 on the cycle start is accepted.
- Command priority (sampled each cycle): stop > start > step.
- FSM states: IDLE, RUN, WAIT, LATCH. A wait counter loads ROM_LAT-1 on entry to WAIT.
- IDLE:
  - start: rom_addr←0; mode=auto; go to WAIT.
  - else step: rom_addr←rom_addr+1 (wrap rule applies); mode=single; go to WAIT.
  - stop is ignored.
- RUN:
  - stop: go to IDLE.
  - else step_tick: rom_addr←rom_addr+1; go to WAIT.
  - start and step are ignored.
- WAIT: decrement the wait counter; at 0, go to LATCH. ROM_LAT=1 therefore spends exactly 1 cycle in WAIT.
- LATCH:
  - disp_data←rom_data.
  - Then go to IDLE if mode=single or pending_stop=1, else RUN.
  - pending_stop clears on leaving LATCH.
- Stop during WAIT or LATCH sets pending_stop. The in-flight fetch always completes and latches before IDLE.
- Latency: disp_data updates ROM_LAT+1 cycles after the rom_addr change.
- Wrap:
  - When an increment takes rom_addr from 2^ADDR_W-1 to 0, wrap=1 for that same cycle.
  - The start load to 0 does not assert wrap.
- A step_tick arriving while in WAIT or LATCH is dropped, not queued.
- Scan:
  - 2-bit index increments on scan_tick and wraps 3→0, independent of FSM state.
  - an = ~(4'b0001 << index).
  - digit = disp_data[4*index+3 : 4*index]. Digit 0 is the least significant nibble.
- All outputs are registered except digit and an, which are decoded from registered index and disp_data.
- Reset asserted mid-fetch aborts immediately: all state returns to reset values and nothing is latched.

Test Plan:
(Params for all: STEP_BITS=3, SCAN_BITS=2, ADDR_W=2, ROM_LAT=1. ROM model: word[a]=16'h1111*(a+1), 1-cycle latency.)
- Reset: hold clr=0, then release → rom_addr=0, disp_data=16'h0000, an=4'b1110, busy=0, wrap=0.
- Start pulse 1 cycle → busy=1 next cycle; rom_addr=0; disp_data=16'h1111 two cycles after start; state RUN.
- Auto-run for 32 cycles → rom_addr steps 0→1→2→3→0 every 8 cycles. wrap pulses exactly once, on the 3→0 increment. disp_data follows 2222, 3333, 4444, 1111.
- Stop asserted in the WAIT cycle after a step to addr 2 → disp_data still becomes 16'h3333. Next state is IDLE; busy=0 one cycle after LATCH; rom_addr holds 2.
- In IDLE, step pulse → rom_addr 2→3, disp_data=16'h4444 two cycles later, returns to IDLE. start+step asserted together → start wins and rom_addr=0.
- Scan with disp_data=16'h4321 → an cycles 1110, 1101, 1011, 0111, changing every 4 cycles. digit shows 1, 2, 3, 4 respectively. Asserting clr=0 mid-scan → an=1110 immediately.
